// File: rtl/key_event_pkg.sv
// key_event_pkg: shared encodings and helpers for the key event scheduler
package key_event_pkg;
    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_LONG    = 2'd1,
        EVT_REPEAT  = 2'd2,
        EVT_RELEASE = 2'd3
    } evt_type_t;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } key_state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/key_event_sched_if.sv
// key_event_sched_if: serialised key event port (valid/ready) plus drop counter
interface key_event_sched_if #(
    parameter int NUM_KEYS = 4
);
    import key_event_pkg::*;
    localparam int KW = clog2(NUM_KEYS);
    logic          evt_valid;
    logic          evt_ready;
    logic [KW-1:0] evt_key;
    evt_type_t     evt_type;
    logic [7:0]    drop_cnt;
    modport master (output evt_valid, evt_key, evt_type, drop_cnt, input evt_ready);
    modport slave  (input evt_valid, evt_key, evt_type, drop_cnt, output evt_ready);
endinterface

// File: rtl/key_event_fsm.sv
// key_event_fsm: per-key edge detect, press/long/repeat FSM and one-deep pending slot
// RELEASE events are posted only when KEYEVT_RELEASE_EN is defined
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int LONG_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      key_n,
    input  logic      grant,
    output logic      pend_valid,
    output evt_type_t pend_type,
    output logic      drop
);
`ifdef KEYEVT_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif
    localparam int TW = clog2(LONG_CYC);
    localparam logic [TW-1:0] LONG_TC = TW'(LONG_CYC - 1);
    localparam logic [TW-1:0] REP_TC  = TW'(REPEAT_CYC - 1);

    key_state_t    state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic          key_q, armed, fall, rise, post;
    evt_type_t     post_type;

    // armed masks the first sample after reset so a key held through reset is not a new press
    assign fall = key_q & ~key_n & armed;
    assign rise = ~key_q & key_n;
    assign drop = post & pend_valid & ~grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b1;
            armed <= 1'b0;
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            key_q <= key_n;
            armed <= 1'b1;
            state <= state_d;
            timer <= timer_d;
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        post      = 1'b0;
        post_type = EVT_PRESS;
        case (state)
            ST_IDLE: if (fall) begin
                state_d = ST_PRESSED;
                timer_d = '0;
                post    = 1'b1;
            end
            ST_PRESSED, ST_HELD: if (rise) begin
                state_d   = ST_IDLE;
                timer_d   = '0;
                post      = REL_EN;
                post_type = EVT_RELEASE;
            end else if (timer == ((state == ST_HELD) ? REP_TC : LONG_TC)) begin
                state_d   = ST_HELD;
                timer_d   = '0;
                post      = 1'b1;
                post_type = (state == ST_HELD) ? EVT_REPEAT : EVT_LONG;
            end else begin
                timer_d = timer + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // a grant in the same cycle empties the slot first, so the new post is never a drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_type  <= EVT_PRESS;
        end else if (post && (!pend_valid || grant || post_type != EVT_REPEAT)) begin
            pend_valid <= 1'b1;
            pend_type  <= post_type;
        end else if (grant) begin
            pend_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/key_event_sched.sv
// key_event_sched: per-key event FSMs with round-robin serialisation onto one valid/ready port
// KEYEVT_RELEASE_EN enables RELEASE events in the per-key FSMs
module key_event_sched
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS   = 4,
    parameter int LONG_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    key_event_sched_if.master   evt
);
    localparam int KW = clog2(NUM_KEYS);

    logic [NUM_KEYS-1:0] pend_valid, grant, drop;
    evt_type_t           pend_type [NUM_KEYS];
    logic [KW-1:0]       rr_ptr, gnt_idx;
    logic                gnt_any, load;
    logic [3:0]          drop_n;
    logic [8:0]          drop_sum;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_event_fsm #(
            .LONG_CYC  (LONG_CYC),
            .REPEAT_CYC(REPEAT_CYC)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_n     (key_n[k]),
            .grant     (grant[k]),
            .pend_valid(pend_valid[k]),
            .pend_type (pend_type[k]),
            .drop      (drop[k])
        );
    end

    // scan downward so the key nearest after rr_ptr is the last (winning) assignment
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr_ptr;
        for (int i = NUM_KEYS; i >= 1; i--) begin
            if (pend_valid[(int'(rr_ptr) + i) % NUM_KEYS]) begin
                gnt_any = 1'b1;
                gnt_idx = KW'((int'(rr_ptr) + i) % NUM_KEYS);
            end
        end
    end

    assign load  = !evt.evt_valid || evt.evt_ready;
    assign grant = (load && gnt_any) ? ({{(NUM_KEYS-1){1'b0}}, 1'b1} << gnt_idx) : '0;

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_KEYS; i++) drop_n = drop_n + {3'b000, drop[i]};
        drop_sum = {1'b0, evt.drop_cnt} + {5'b00000, drop_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt.evt_valid <= 1'b0;
            evt.evt_key   <= '0;
            evt.evt_type  <= EVT_PRESS;
            evt.drop_cnt  <= '0;
            rr_ptr        <= KW'(NUM_KEYS - 1);
        end else begin
            evt.drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
            if (load) begin
                evt.evt_valid <= gnt_any;
                if (gnt_any) begin
                    evt.evt_key  <= gnt_idx;
                    evt.evt_type <= pend_type[gnt_idx];
                    rr_ptr       <= gnt_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_event_sched.sv
// tb_key_event_sched: directed scenarios checked against a duration-based event model every cycle
module tb_key_event_sched;
    import key_event_pkg::*;
    localparam int NK = 4;
    localparam int LC = 10;
    localparam int RC = 4;
`ifdef KEYEVT_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    typedef struct {
        int cyc;
        int key;
        int typ;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_n = '1;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    rec_t          log_q[$];
    rec_t          exp_q[$];

    bit m_valid, m_armed, m_load;
    int m_key, m_type, m_rr, m_drop, m_g, m_ev;
    bit m_pv[NK];
    int m_pt[NK];
    bit m_held[NK];
    bit m_prev[NK];
    int m_n[NK];

    key_event_sched_if #(.NUM_KEYS(NK)) evt ();

    key_event_sched #(
        .NUM_KEYS  (NK),
        .LONG_CYC  (LC),
        .REPEAT_CYC(RC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_n),
        .evt  (evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_key = 0; m_type = 0; m_rr = NK - 1; m_drop = 0; m_armed = 0;
        for (int k = 0; k < NK; k++) begin
            m_pv[k] = 0; m_pt[k] = 0; m_held[k] = 0; m_prev[k] = 1; m_n[k] = 0;
        end
    endtask

    // events follow from how long each key has been continuously low since its press
    task automatic model_step();
        m_load = !m_valid || evt.evt_ready;
        m_g = -1;
        if (m_load) begin
            for (int i = 1; i <= NK; i++)
                if (m_g < 0 && m_pv[(m_rr + i) % NK]) m_g = (m_rr + i) % NK;
            m_valid = (m_g >= 0);
            if (m_g >= 0) begin
                m_key = m_g; m_type = m_pt[m_g]; m_pv[m_g] = 0; m_rr = m_g;
            end
        end
        for (int k = 0; k < NK; k++) begin
            m_ev = -1;
            if (m_held[k]) begin
                if (!key_n[k]) begin
                    m_n[k]++;
                    if (m_n[k] == LC) m_ev = 1;
                    else if (m_n[k] > LC && (m_n[k] - LC) % RC == 0) m_ev = 2;
                end else begin
                    m_held[k] = 0;
                    if (REL) m_ev = 3;
                end
            end else if (!key_n[k] && m_prev[k] && m_armed) begin
                m_held[k] = 1; m_n[k] = 0; m_ev = 0;
            end
            m_prev[k] = key_n[k];
            if (m_ev >= 0) begin
                if (!m_pv[k]) begin
                    m_pv[k] = 1; m_pt[k] = m_ev;
                end else begin
                    if (m_drop < 255) m_drop++;
                    if (m_ev != 2) m_pt[k] = m_ev;
                end
            end
        end
        m_armed = 1;
    endtask

    initial forever begin
        rec_t r;
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else begin
            cyc++;
            if (evt.evt_valid && evt.evt_ready) begin
                r.cyc = cyc; r.key = int'(evt.evt_key); r.typ = int'(evt.evt_type);
                log_q.push_back(r);
            end
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("evt_valid", int'(evt.evt_valid), int'(m_valid));
        if (m_valid) begin
            chk("evt_key", int'(evt.evt_key), m_key);
            chk("evt_type", int'(evt.evt_type), m_type);
        end
        chk("drop_cnt", int'(evt.drop_cnt), m_drop);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_n = '1;
        evt.evt_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        log_q.delete();
    endtask

    task automatic expect_evt(input int k, input int t);
        rec_t r;
        r.cyc = 0; r.key = k; r.typ = t;
        exp_q.push_back(r);
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_count"}, log_q.size(), exp_q.size());
        if (log_q.size() == exp_q.size())
            foreach (exp_q[i]) begin
                chk({nm, "_key"}, log_q[i].key, exp_q[i].key);
                chk({nm, "_type"}, log_q[i].typ, exp_q[i].typ);
            end
        exp_q.delete();
        log_q.delete();
    endtask

    initial begin
        evt.evt_ready = 1'b1;
        do_reset();
        chk("reset_valid", int'(evt.evt_valid), 0);
        chk("reset_drop", int'(evt.drop_cnt), 0);

        // short tap on key1
        key_n[1] = 1'b0;
        tick(1);
        chk("tap_lat1_valid", int'(evt.evt_valid), 0);
        tick(1);
        chk("tap_lat2_valid", int'(evt.evt_valid), 1);
        chk("tap_lat2_key", int'(evt.evt_key), 1);
        chk("tap_lat2_type", int'(evt.evt_type), 0);
        tick(3);
        key_n[1] = 1'b1;
        tick(4);
        expect_evt(1, 0);
        if (REL) expect_evt(1, 3);
        check_log("tap");
        chk("tap_drop", int'(evt.drop_cnt), 0);

        // long hold on key2: 32 low samples give LONG at 10 and REPEATs at 14,18,22,26,30
        do_reset();
        key_n[2] = 1'b0;
        tick(32);
        key_n[2] = 1'b1;
        tick(4);
        if (log_q.size() >= 3) begin
            chk("hold_long_gap", log_q[1].cyc - log_q[0].cyc, 10);
            chk("hold_rep_gap", log_q[2].cyc - log_q[1].cyc, 4);
        end
        expect_evt(2, 0);
        expect_evt(2, 1);
        for (int i = 0; i < 5; i++) expect_evt(2, 2);
        if (REL) expect_evt(2, 3);
        check_log("hold");

        // simultaneous presses and round-robin order
        do_reset();
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        tick(4);
        if (log_q.size() == 2) chk("sim_gap", log_q[1].cyc - log_q[0].cyc, 1);
        expect_evt(0, 0);
        expect_evt(3, 0);
        check_log("sim_press");
        key_n[0] = 1'b1;
        key_n[3] = 1'b1;
        tick(4);
        if (REL) begin
            expect_evt(0, 3);
            expect_evt(3, 3);
        end
        check_log("sim_release");
        key_n[2] = 1'b0;
        tick(4);
        key_n[1] = 1'b0;
        key_n[3] = 1'b0;
        tick(4);
        expect_evt(2, 0);
        expect_evt(3, 0);
        expect_evt(1, 0);
        check_log("sim_rr");

        // backpressure while key0 is held
        do_reset();
        evt.evt_ready = 1'b0;
        key_n[0] = 1'b0;
        tick(30);
        key_n[0] = 1'b1;
        tick(10);
        chk("bp_valid", int'(evt.evt_valid), 1);
        chk("bp_key", int'(evt.evt_key), 0);
        chk("bp_type", int'(evt.evt_type), 0);
        chk("bp_drop", int'(evt.drop_cnt), REL ? 5 : 4);
        evt.evt_ready = 1'b1;
        tick(4);
        expect_evt(0, 0);
        expect_evt(0, REL ? 3 : 1);
        check_log("bp");

        // reset while key2 is in the held state
        do_reset();
        key_n[2] = 1'b0;
        tick(15);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", int'(evt.evt_valid), 0);
        tick(2);
        rst_n = 1'b1;
        log_q.delete();
        tick(20);
        check_log("rst_quiet");
        key_n[2] = 1'b1;
        tick(3);
        key_n[2] = 1'b0;
        tick(4);
        expect_evt(2, 0);
        check_log("rst_repress");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
